// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Register indices follow pipeline order: IF/ID, ID/EX, EX/MEM, MEM/WB.
package pipe_ctrl_pkg;

  localparam int REG_CNT  = 4;
  localparam int R_IF_ID  = 0;
  localparam int R_ID_EX  = 1;
  localparam int R_EX_MEM = 2;
  localparam int R_MEM_WB = 3;

  typedef enum logic {
    RUN    = 1'b0,
    REFILL = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'b00,
    PC_REDIR = 2'b01,
    PC_TRAP  = 2'b10
  } pc_sel_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare between the ID sources and a load in EX.
// x0 is never a real dependency, so a load targeting it never stalls.
module pipe_hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline, with IMEM refill tracking.
// Define PIPE_CTRL_PERF_EN to add stall-cycle and flush-event performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic               ex_is_load,
  input  logic [4:0]         ex_rd,
  input  logic               ex_redirect,
  input  logic               mem_busy,
  input  logic               mem_trap,
  output logic               pc_en,
  output logic [1:0]         pc_sel,
  output logic [REG_CNT-1:0] reg_en,
  output logic [REG_CNT-1:0] reg_flush,
  output logic [REG_CNT-1:0] reg_bubble,
  output logic               refill_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   perf_stall_cyc,
  output logic [CNT_W-1:0]   perf_flush_evt
`endif
);

  if (IMEM_LAT < 0 || IMEM_LAT > 7 || CNT_W < 1) begin : g_param_check
    $error("pipe_ctrl: IMEM_LAT must be 0..7 and CNT_W must be >= 1");
  end

  localparam logic [2:0] LAT = 3'(IMEM_LAT);

  state_e     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  pc_sel_e    sel;
  logic       load_use;

  pipe_hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  // NOTE: every output and next-state variable gets a default first so no path infers a latch.
  always_comb begin
    pc_en      = 1'b1;
    reg_en     = '1;
    reg_flush  = '0;
    reg_bubble = '0;
    sel        = PC_SEQ;
    state_nxt  = state;
    cnt_nxt    = cnt;

    // Fetched data is invalid while the IMEM refills after a redirect.
    if (state == REFILL) reg_bubble[R_IF_ID] = 1'b1;

    if (rst) begin
      pc_en      = 1'b0;
      reg_en     = '0;
      reg_flush  = '1;
      reg_bubble = '0;
    end else if (mem_busy) begin
      // Only WB advances; held trap/redirect requests act once MEM completes.
      pc_en                      = 1'b0;
      reg_en[R_EX_MEM:R_IF_ID]   = '0;
      reg_bubble[R_MEM_WB]       = 1'b1;
    end else if (mem_trap || ex_redirect) begin
      reg_bubble[R_IF_ID] = 1'b1;
      if (mem_trap) begin
        sel                         = PC_TRAP;
        reg_flush[R_EX_MEM:R_IF_ID] = '1;
      end else begin
        sel                 = PC_REDIR;
        reg_flush[R_IF_ID]  = 1'b1;
      end
      if (LAT != 3'd0) begin
        state_nxt = REFILL;
        cnt_nxt   = LAT;
      end
    end else if (load_use) begin
      pc_en               = 1'b0;
      reg_en[R_IF_ID]     = 1'b0;
      reg_bubble[R_ID_EX] = 1'b1;
    end else if (state == REFILL) begin
      cnt_nxt = cnt - 3'd1;
      if (cnt == 3'd1) state_nxt = RUN;
    end
  end

  assign pc_sel      = sel;
  assign refill_busy = (state == REFILL) && !rst;

  // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_evt <= '0;
    end else begin
      if (!pc_en) perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (!mem_busy && (mem_trap || ex_redirect)) perf_flush_evt <= perf_flush_evt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level reference model that counts remaining refill cycles.
module tb_pipe_ctrl;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_is_load;
  logic       ex_redirect, mem_busy, mem_trap;
  logic       pc_en, refill_busy;
  logic [1:0] pc_sel;
  logic [3:0] reg_en, reg_flush, reg_bubble;

  int n_checks = 0;
  int n_errors = 0;
  int refill_left = 0;

  logic [15:0] obs;
  assign obs = {pc_en, pc_sel, reg_en, reg_flush, reg_bubble, refill_busy};

  pipe_ctrl #(.IMEM_LAT(LAT), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .mem_busy    (mem_busy),
    .mem_trap    (mem_trap),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .reg_en      (reg_en),
    .reg_flush   (reg_flush),
    .reg_bubble  (reg_bubble),
    .refill_busy (refill_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (pc_en,pc_sel,en,flush,bubble,refill)", tag, got, exp);
    end
  endtask

  function automatic logic depends_on_load();
    logic hit;
    hit = 1'b0;
    if (ex_is_load && ex_rd != 5'd0) begin
      if (id_rs1_used && id_rs1 == ex_rd) hit = 1'b1;
      if (id_rs2_used && id_rs2 == ex_rd) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [15:0] model_out();
    logic       rf, pe;
    logic [1:0] ps;
    logic [3:0] en, fl, bb;
    if (rst) return {1'b0, 2'b00, 4'h0, 4'hF, 4'h0, 1'b0};
    rf = (refill_left > 0);
    pe = 1'b1;
    ps = 2'b00;
    en = 4'hF;
    fl = 4'h0;
    bb = {3'b000, rf};
    if (mem_busy) begin
      pe = 1'b0; en = 4'b1000; bb = bb | 4'b1000;
    end else if (mem_trap) begin
      ps = 2'b10; fl = 4'b0111; bb = 4'b0001;
    end else if (ex_redirect) begin
      ps = 2'b01; fl = 4'b0001; bb = 4'b0001;
    end else if (depends_on_load()) begin
      pe = 1'b0; en = 4'b1110; bb = bb | 4'b0010;
    end
    return {pe, ps, en, fl, bb, rf};
  endfunction

  // Advance the model across a rising edge using the inputs that were present.
  task automatic model_step();
    if (rst) refill_left = 0;
    else if (mem_busy) ;
    else if (mem_trap || ex_redirect) refill_left = LAT;
    else if (depends_on_load()) ;
    else if (refill_left > 0) refill_left--;
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic cycle(input string tag);
    #2 check(tag, obs, model_out());
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_is_load = 1'b0; ex_rd = 5'd0;
    ex_redirect = 1'b0; mem_busy = 1'b0; mem_trap = 1'b0;
  endtask

  task automatic randomize_inputs();
    mem_busy    = ($urandom_range(0, 4) == 0);
    mem_trap    = ($urandom_range(0, 19) == 0);
    ex_redirect = ($urandom_range(0, 7) == 0);
    ex_is_load  = 1'($urandom_range(0, 1));
    ex_rd       = 5'($urandom_range(0, 3));
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    id_rs1_used = 1'($urandom_range(0, 1));
    id_rs2_used = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3 check("reset", obs, {1'b0, 2'b00, 4'h0, 4'hF, 4'h0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    refill_left = 0;
    cycle("idle_default");

    // Load-use via rs1, then the load has moved on.
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    cycle("ld_use_rs1");
    idle();
    cycle("ld_use_after");

    // Load-use via rs2; then an unused rs2 match must not stall.
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    cycle("ld_use_rs2");
    id_rs2_used = 1'b0;
    cycle("ld_use_unused");

    // x0 guard.
    idle();
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    cycle("x0_guard");

    // Redirect followed by LAT refill cycles.
    idle();
    ex_redirect = 1'b1;
    cycle("redir");
    idle();
    for (int i = 0; i < LAT + 1; i++) cycle($sformatf("redir_refill%0d", i));

    // mem_busy holds a redirect for three cycles.
    mem_busy = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("busy_hold%0d", i));
    mem_busy = 1'b0;
    cycle("busy_release_redir");
    idle();
    for (int i = 0; i < LAT + 1; i++) cycle($sformatf("busy_refill%0d", i));

    // Trap beats a simultaneous redirect and load-use.
    mem_trap = 1'b1; ex_redirect = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    cycle("trap_prio");
    idle();
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    cycle("refill_ld_use");
    idle();
    for (int i = 0; i < LAT + 1; i++) cycle($sformatf("trap_refill%0d", i));

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs();
      cycle("rand");
    end

    // Drain, then assert reset asynchronously with one refill cycle left.
    idle();
    for (int i = 0; i < 8; i++) cycle("drain");
    ex_redirect = 1'b1;
    cycle("pre_rst_redir");
    idle();
    cycle("pre_rst_refill");
    #2 check("pre_rst_busy", obs, model_out());
    rst = 1'b1;
    #1 check("rst_async", obs, {1'b0, 2'b00, 4'h0, 4'hF, 4'h0, 1'b0});
    refill_left = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle("rst_post");
    cycle("rst_post2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives en/flush of the four pipeline registers (0=if_id, 1=id_ex, 2=ex_mem, 3=mem_wb), plus a per-register bubble (din-zero) gate and the PC enable/select.
- Resolves load-use hazards, EX branch redirects, MEM stalls and MEM traps, and sequences IMEM refill after any redirect.

Parameters:
- IMEM_LAT, 1, extra fetch-latency cycles after a PC redirect during which fetched data is invalid (0..7).
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_rs1, id_rs2  in  5 each  ID source registers
- id_rs1_used, id_rs2_used  in  1 each  ID source actually read
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_redirect  in  1  EX branch/jump taken (target on datapath)
- mem_busy  in  1  data memory not ready; MEM cannot complete
- mem_trap  in  1  MEM instruction raises trap
- pc_en  out  1  PC register enable
- pc_sel  out  2  00 sequential, 01 EX redirect target, 10 trap vector
- reg_en  out  4  pipeline register enables
- reg_flush  out  4  kill register's current output (zeroed same cycle)
- reg_bubble  out  4  zero register's din (insert bubble without killing output)
- refill_busy  out  1  state==REFILL

Behaviour:
- Flush semantics: reg_flush[i] zeroes the register output combinationally and captures zero when reg_en[i]=1. reg_bubble[i] only zeroes din.
- States: RUN, REFILL. 3-bit refill counter cnt.
- Reset (async, rst=1): state=RUN, cnt=0. Outputs while rst=1: pc_en=0, reg_en=0, reg_flush=4'b1111, reg_bubble=0, pc_sel=00, refill_busy=0.
- Default (no event, RUN): pc_en=1, reg_en=4'b1111, reg_flush=0, reg_bubble=0, pc_sel=00.
- Priority per cycle: mem_busy > mem_trap > ex_redirect > load-use.
- mem_busy=1:
  - pc_en=0, reg_en[2:0]=0.
  - reg_en[3]=1, reg_bubble[3]=1 (WB gets bubble; WB instr retires).
  - mem_trap and ex_redirect are ignored this cycle; the datapath holds them, and they act when mem_busy falls.
  - cnt and state frozen.
- mem_trap (mem_busy=0):
  - reg_flush[2:0]=3'b111 kills ID, EX and MEM.
  - pc_sel=10, pc_en=1, reg_bubble[0]=1.
  - If IMEM_LAT>0: state<=REFILL, cnt<=IMEM_LAT.
- ex_redirect:
  - reg_flush[0]=1 kills ID; reg_bubble[0]=1.
  - pc_sel=01, pc_en=1.
  - REFILL entry as for trap.
  - Takes precedence over a simultaneous load-use; the ID instr is wrong-path.
- Load-use:
  - Condition: ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - pc_en=0, reg_en[0]=0, reg_bubble[1]=1.
  - Exactly one stall cycle per load (the load leaves EX).
- REFILL:
  - Default outputs plus reg_bubble[0]=1 (fetched data invalid).
  - cnt decrements each non-busy cycle; cnt==1 -> RUN next cycle.
  - A new redirect/trap in REFILL reloads cnt=IMEM_LAT.
  - A load-use in REFILL still stalls, with cnt frozen.
- IMEM_LAT=0: REFILL is never entered; the redirect cycle alone inserts a single bubble.
- Reset mid-REFILL returns immediately to RUN.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: outputs perf_stall_cyc[CNT_W] and perf_flush_evt[CNT_W], both reset 0 and wrapping at 2^CNT_W.
  - perf_stall_cyc increments each cycle pc_en=0 (rst=0).
  - perf_flush_evt increments on each accepted redirect or trap.
- Undefined: ports and counters absent. Core behaviour is identical either way.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum (RUN, REFILL)
  - pc_sel enum (PC_SEQ, PC_REDIR, PC_TRAP)
  - register index constants (R_IF_ID=0..R_MEM_WB=3)
  - REG_CNT=4
- One sub-module pipe_hazard_detect: combinational load-use compare, producing load_use.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle of pc_en=0, reg_en=4'b1110, reg_bubble=4'b0010; the next cycle is default.
- x0 guard: ex_rd=0, id_rs1=0, id_rs1_used=1, ex_is_load=1 -> no stall.
- Redirect with IMEM_LAT=2: ex_redirect pulse -> that cycle pc_sel=01, reg_flush=4'b0001; then 2 cycles refill_busy=1, reg_bubble[0]=1; then RUN.
- mem_busy held 3 cycles with ex_redirect=1 -> 3 cycles pc_en=0, reg_en=4'b1000, reg_bubble=4'b1000; the redirect takes effect in cycle 4.
- mem_trap together with ex_redirect and load-use -> pc_sel=10, reg_flush=4'b0111; state REFILL, cnt=IMEM_LAT.
- rst asserted asynchronously mid-REFILL (cnt=1) -> outputs immediately at reset values; after release, state RUN and default outputs.
